// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART tx core among NUM_REQ byte sources.
// Latency: gnt/tx_start one cycle after req; cmp one cycle after tx_done.
// Backpressure: req is ignored while a frame is in flight (busy); watchdog aborts on a missing tx_done.
module uart_tx_arbiter #(
  parameter  int NUM_REQ        = 4,
  parameter  int TIMEOUT_CYCLES = 12000,
  localparam int ID_W           = $clog2(NUM_REQ)
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*8-1:0] req_data,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   cmp,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_done,
  output logic                 busy,
  output logic [ID_W-1:0]      active_id,
  output logic                 timeout_err
);

  localparam int                WDT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WDT_W-1:0]  WDT_LAST = WDT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WDT_W-1:0]  WDT_MAX  = {WDT_W{1'b1}};

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t             state, nxt_state;
  logic [ID_W-1:0]    ptr, nxt_ptr;
  logic [WDT_W-1:0]   wdt, nxt_wdt;
  logic [ID_W-1:0]    win;
  logic [ID_W:0]      scan_idx;
  logic [ID_W-1:0]    ptr_after;
  logic               wdt_last;
  logic [NUM_REQ-1:0] nxt_gnt, nxt_cmp;
  logic               nxt_tx_start, nxt_busy, nxt_timeout_err;
  logic [7:0]         nxt_tx_data;
  logic [ID_W-1:0]    nxt_active_id;

  // Winner: first set req bit scanning upward from ptr with wrap; the
  // downward loop leaves the lowest offset (closest to ptr) as the result.
  always_comb begin
    win      = '0;
    scan_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      scan_idx = {1'b0, ptr} + (ID_W + 1)'(k);
      if (scan_idx >= (ID_W + 1)'(NUM_REQ))
        scan_idx = scan_idx - (ID_W + 1)'(NUM_REQ);
      if (req[scan_idx[ID_W-1:0]])
        win = scan_idx[ID_W-1:0];
    end
  end

  assign wdt_last  = (wdt == WDT_LAST);
  assign ptr_after = (active_id == ID_W'(NUM_REQ - 1)) ? '0 : active_id + 1'b1;

  // State register.
  always_ff @(posedge clock) begin
    if (rst) state <= IDLE;
    else     state <= nxt_state;
  end

  // Next-state: leave IDLE on any request, leave WAIT on done or watchdog expiry.
  always_comb begin
    nxt_state = state;
    case (state)
      IDLE:    if (|req) nxt_state = WAIT;
      WAIT:    if (tx_done || wdt_last) nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  // Output/datapath next values; pulses default low, held values default to hold.
  always_comb begin
    nxt_gnt         = '0;
    nxt_cmp         = '0;
    nxt_tx_start    = 1'b0;
    nxt_timeout_err = 1'b0;
    nxt_tx_data     = tx_data;
    nxt_busy        = busy;
    nxt_active_id   = active_id;
    nxt_ptr         = ptr;
    nxt_wdt         = wdt;
    case (state)
      IDLE: begin
        if (|req) begin
          nxt_gnt       = NUM_REQ'(1) << win;
          nxt_tx_start  = 1'b1;
          nxt_tx_data   = req_data[8*win +: 8];
          nxt_active_id = win;
          nxt_busy      = 1'b1;
          nxt_wdt       = '0;
        end
      end
      WAIT: begin
        if (wdt != WDT_MAX) nxt_wdt = wdt + 1'b1;
        // done takes priority over a watchdog expiry in the same cycle
        if (tx_done) begin
          nxt_cmp  = NUM_REQ'(1) << active_id;
          nxt_busy = 1'b0;
          nxt_ptr  = ptr_after;
        end else if (wdt_last) begin
          nxt_timeout_err = 1'b1;
          nxt_busy        = 1'b0;
          nxt_ptr         = ptr_after;
        end
      end
      default: ;
    endcase
  end

  // Registered outputs, pointer and watchdog.
  always_ff @(posedge clock) begin
    if (rst) begin
      gnt         <= '0;
      cmp         <= '0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      busy        <= 1'b0;
      active_id   <= '0;
      timeout_err <= 1'b0;
      ptr         <= '0;
      wdt         <= '0;
    end else begin
      gnt         <= nxt_gnt;
      cmp         <= nxt_cmp;
      tx_start    <= nxt_tx_start;
      tx_data     <= nxt_tx_data;
      busy        <= nxt_busy;
      active_id   <= nxt_active_id;
      timeout_err <= nxt_timeout_err;
      ptr         <= nxt_ptr;
      wdt         <= nxt_wdt;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed stimulus pushes expected gnt/cmp/timeout
// events with their cycle numbers; a negedge monitor pops and compares them.
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int TMO = 16;

  logic          clock = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic [N*8-1:0] req_data;
  logic [N-1:0]  gnt, cmp;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic          tx_done;
  logic          busy;
  logic [1:0]    active_id;
  logic          timeout_err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [N-1:0] vec;
    logic [7:0]   dat;
    logic [1:0]   id;
    int           cyc;
  } gexp_t;

  typedef struct {
    logic [N-1:0] vec;
    int           cyc;
  } cexp_t;

  gexp_t gnt_q[$];
  cexp_t cmp_q[$];
  int    to_q[$];
  gexp_t mon_g;
  cexp_t mon_c;
  int    mon_t;

  uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TMO)) dut (
    .clock       (clock),
    .rst         (rst),
    .req         (req),
    .req_data    (req_data),
    .gnt         (gnt),
    .cmp         (cmp),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_done     (tx_done),
    .busy        (busy),
    .active_id   (active_id),
    .timeout_err (timeout_err)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: every output pulse must match the head of its expectation queue.
  always @(negedge clock) begin
    if (gnt != '0 || tx_start) begin
      total++;
      if (gnt_q.size() == 0) begin
        bad++;
        $display("FAIL gnt_unexpected: gnt=%b tx_start=%b cycle=%0d", gnt, tx_start, cyc);
      end else begin
        mon_g = gnt_q.pop_front();
        if (gnt !== mon_g.vec || tx_start !== 1'b1 || tx_data !== mon_g.dat ||
            active_id !== mon_g.id || busy !== 1'b1 || cyc != mon_g.cyc) begin
          bad++;
          $display("FAIL gnt: got gnt=%b start=%b data=%h id=%0d busy=%b cyc=%0d want gnt=%b start=1 data=%h id=%0d busy=1 cyc=%0d",
                   gnt, tx_start, tx_data, active_id, busy, cyc,
                   mon_g.vec, mon_g.dat, mon_g.id, mon_g.cyc);
        end
      end
    end
    if (cmp != '0) begin
      total++;
      if (cmp_q.size() == 0) begin
        bad++;
        $display("FAIL cmp_unexpected: cmp=%b cycle=%0d", cmp, cyc);
      end else begin
        mon_c = cmp_q.pop_front();
        if (cmp !== mon_c.vec || busy !== 1'b0 || timeout_err !== 1'b0 || cyc != mon_c.cyc) begin
          bad++;
          $display("FAIL cmp: got cmp=%b busy=%b to=%b cyc=%0d want cmp=%b busy=0 to=0 cyc=%0d",
                   cmp, busy, timeout_err, cyc, mon_c.vec, mon_c.cyc);
        end
      end
    end
    if (timeout_err) begin
      total++;
      if (to_q.size() == 0) begin
        bad++;
        $display("FAIL timeout_unexpected: cycle=%0d", cyc);
      end else begin
        mon_t = to_q.pop_front();
        if (cmp !== '0 || busy !== 1'b0 || cyc != mon_t) begin
          bad++;
          $display("FAIL timeout: got cmp=%b busy=%b cyc=%0d want cmp=0 busy=0 cyc=%0d",
                   cmp, busy, cyc, mon_t);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reset for two cycles, checking every output is zero after the first edge.
  task automatic do_reset();
    rst = 1'b1;
    tick();
    total++;
    if ({gnt, cmp, tx_start, tx_data, busy, active_id, timeout_err} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: gnt=%b cmp=%b start=%b data=%h busy=%b id=%0d to=%b want all 0",
               gnt, cmp, tx_start, tx_data, busy, active_id, timeout_err);
    end
    tick();
    rst = 1'b0;
  endtask

  // Request with r, expect requester id to win; leaves the bench in the gnt cycle.
  task automatic grant_only(input logic [N-1:0] r, input int id, input bit drop, output int g);
    gexp_t e;
    req   = r;
    e.vec = N'(1) << id;
    e.dat = req_data[8*id +: 8];
    e.id  = 2'(id);
    e.cyc = cyc + 1;
    gnt_q.push_back(e);
    tick();
    g = cyc;
    if (drop) req = '0;
  endtask

  // Full transaction: grant, then tx_done 'delay' cycles after tx_start.
  task automatic serve(input logic [N-1:0] r, input int id, input int delay, input bit drop);
    cexp_t c;
    int    g;
    grant_only(r, id, drop, g);
    repeat (delay) tick();
    tx_done = 1'b1;
    c.vec   = N'(1) << id;
    c.cyc   = cyc + 1;
    cmp_q.push_back(c);
    tick();
    tx_done = 1'b0;
  endtask

  initial begin
    int g;
    rst      = 1'b1;
    req      = '0;
    req_data = '0;
    tx_done  = 1'b0;
    do_reset();

    // single requester
    req_data = 32'h00A5_0000;
    serve(4'b0100, 2, 10, 1'b1);
    tick();

    // round robin with all requests held
    do_reset();
    req_data = 32'h4433_2211;
    serve(4'b1111, 0, 5, 1'b0);
    serve(4'b1111, 1, 5, 1'b0);
    serve(4'b1111, 2, 5, 1'b0);
    serve(4'b1111, 3, 5, 1'b0);
    serve(4'b1111, 0, 5, 1'b0);
    serve(4'b1111, 1, 5, 1'b1);

    // pointer wrap: ptr=2, only requester 0 asks
    serve(4'b0001, 0, 5, 1'b1);
    serve(4'b1111, 1, 5, 1'b1);

    // watchdog timeout on requester 3
    grant_only(4'b1000, 3, 1'b1, g);
    to_q.push_back(g + TMO);
    repeat (TMO) tick();
    serve(4'b1111, 0, 5, 1'b1);

    // tx_done coincides with the last watchdog cycle
    serve(4'b0010, 1, TMO - 1, 1'b1);

    // reset in the middle of WAIT, then a stray tx_done
    grant_only(4'b0100, 2, 1'b1, g);
    repeat (3) tick();
    do_reset();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    tick();
    serve(4'b1111, 0, 4, 1'b1);

    repeat (5) tick();
    total++;
    if (gnt_q.size() != 0 || cmp_q.size() != 0 || to_q.size() != 0) begin
      bad++;
      $display("FAIL pending_events: gnt=%0d cmp=%0d timeout=%0d want 0 0 0",
               gnt_q.size(), cmp_q.size(), to_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
